// File: rtl/pmod_led_scheduler_if.sv
// pmod_led_scheduler_if: bundles requester inputs and scheduler LED/grant outputs
// i_req/i_color/i_blink : per-requester request level, {r,g,b} color, blink enable
// o_grant/o_busy        : one-hot owner and busy flag
// o_led_r/g/b           : LED pin drives
interface pmod_led_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req;
    logic [3*NUM_REQ-1:0] i_color;
    logic [NUM_REQ-1:0]   i_blink;
    logic [NUM_REQ-1:0]   o_grant;
    logic                 o_busy;
    logic                 o_led_r;
    logic                 o_led_g;
    logic                 o_led_b;
    modport master (
        output i_req, i_color, i_blink,
        input  o_grant, o_busy, o_led_r, o_led_g, o_led_b
    );
    modport slave (
        input  i_req, i_color, i_blink,
        output o_grant, o_busy, o_led_r, o_led_g, o_led_b
    );
endinterface

// File: rtl/pmod_led_scheduler.sv
// pmod_led_scheduler: fixed-priority sharing of one RGB LED with hold time, PWM dimming and blink
// i_clock  : system clock
// i_nReset : synchronous active-low reset
// bus      : slave side of pmod_led_scheduler_if (requests, colors, blink in; grant, busy, LEDs out)
module pmod_led_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int PWM_PERIOD    = 100,
    parameter int PWM_DUTY      = 10,
    parameter int MIN_HOLD      = 1000,
    parameter int BLINK_PERIODS = 500
) (
    input logic                  i_clock,
    input logic                  i_nReset,
    pmod_led_scheduler_if.slave  bus
);
    localparam int PW = $clog2(PWM_PERIOD);
    localparam int BW = $clog2(BLINK_PERIODS + 1);
    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
    localparam logic [1:0] OPEN   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         color_q, color_d;
    logic               blink_q, blink_d;
    logic               busy_q, busy_d;
    logic [2:0]         led_q, led_d;
    logic [NUM_REQ-1:0] win_oh;
    logic [2:0]         win_color;
    logic               win_blink;
    logic               pwm_on, period_tick, blink_wrap, load;

    assign pwm_on      = int'(pwm_cnt_q) < PWM_DUTY;
    assign period_tick = pwm_cnt_q == PW'(PWM_PERIOD - 1);
    assign blink_wrap  = blink_cnt_q == BW'(BLINK_PERIODS - 1);
    // Isolates the lowest set request bit: index 0 has top priority
    assign win_oh      = bus.i_req & (~bus.i_req + NUM_REQ'(1));
    assign win_blink   = |(bus.i_blink & win_oh);

    always_comb begin
        win_color = '0;
        for (int i = 0; i < NUM_REQ; i++)
            win_color = win_color | (bus.i_color[3*i +: 3] & {3{win_oh[i]}});
    end

    always_comb begin
        pwm_cnt_d     = period_tick ? '0 : pwm_cnt_q + PW'(1);
        blink_cnt_d   = period_tick ? (blink_wrap ? '0 : blink_cnt_q + BW'(1)) : blink_cnt_q;
        blink_phase_d = blink_phase_q ^ (period_tick & blink_wrap);
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        color_d       = color_q;
        blink_d       = blink_q;
        load          = 1'b0;
        if (state_q == IDLE) begin
            load = |bus.i_req;
        end else if (state_q == LOCKED) begin
            if (period_tick) begin
                hold_cnt_d = hold_cnt_q - HW'(1);
                state_d    = (hold_cnt_q == HW'(1)) ? OPEN : LOCKED;
            end
        end else if (!(|bus.i_req)) begin
            state_d = IDLE;
            grant_d = '0;
            color_d = '0;
            blink_d = 1'b0;
        end else begin
            load = win_oh != grant_q;
        end
        // A (re)grant overrides any concurrent hold decrement
        if (load) begin
            state_d    = LOCKED;
            hold_cnt_d = HW'(MIN_HOLD);
            grant_d    = win_oh;
            color_d    = win_color;
            blink_d    = win_blink;
        end
        busy_d = state_d != IDLE;
        led_d  = color_q & {3{pwm_on & (~blink_q | blink_phase_q)}};
    end

    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            state_q       <= IDLE;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            color_q       <= '0;
            blink_q       <= 1'b0;
            busy_q        <= 1'b0;
            led_q         <= '0;
        end else begin
            state_q       <= state_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            color_q       <= color_d;
            blink_q       <= blink_d;
            busy_q        <= busy_d;
            led_q         <= led_d;
        end
    end

    assign bus.o_grant = grant_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_led_r = led_q[2];
    assign bus.o_led_g = led_q[1];
    assign bus.o_led_b = led_q[0];
endmodule

// File: tb/tb_pmod_led_scheduler.sv
// tb_pmod_led_scheduler: scoreboard bench for pmod_led_scheduler with small timing parameters
module tb_pmod_led_scheduler;
    localparam int N = 4;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic       b;
        logic [2:0] l;
        string      n;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    pmod_led_scheduler_if #(.NUM_REQ(N)) bus();

    pmod_led_scheduler #(
        .NUM_REQ(N), .PWM_PERIOD(4), .PWM_DUTY(2), .MIN_HOLD(2), .BLINK_PERIODS(2)
    ) dut (
        .i_clock(clk),
        .i_nReset(nrst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [2:0] led;
        led = {bus.o_led_r, bus.o_led_g, bus.o_led_b};
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            compared++;
            if (e.cyc != cyc || bus.o_grant !== e.g || bus.o_busy !== e.b || led !== e.l) begin
                mismatched++;
                $display("FAIL %s @cyc %0d (tag %0d): grant=%b busy=%b led=%b, expected grant=%b busy=%b led=%b",
                         e.n, cyc, e.cyc, bus.o_grant, bus.o_busy, led, e.g, e.b, e.l);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push(input int t, input logic [3:0] g, input logic b,
                                 input logic [2:0] l, input string n);
        exp_t e;
        e.cyc = t;
        e.g   = g;
        e.b   = b;
        e.l   = l;
        e.n   = n;
        sb.push_back(e);
    endfunction

    function automatic void expect_k(input int k, input logic [3:0] g, input logic b,
                                     input logic [2:0] l, input string n);
        push(base + k, g, b, l, n);
    endfunction

    task automatic set_in(input logic [3:0] r, input logic [11:0] c, input logic [3:0] bl);
        bus.i_req   = r;
        bus.i_color = c;
        bus.i_blink = bl;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            push(cyc, 4'b0000, 1'b0, 3'b000, "reset_hold");
        end
        nrst = 1'b1;
        base = cyc;
    endtask

    function automatic logic pwm_slot(input int k);
        return k > 1 && (k % 4 == 1 || k % 4 == 2);
    endfunction

    initial begin
        set_in(4'b1111, {3'b001, 3'b010, 3'b111, 3'b100}, 4'b0000);
        do_reset();
        expect_k(1, 4'b0001, 1'b1, 3'b000, "t1_first_edge");
        expect_k(2, 4'b0001, 1'b1, 3'b100, "t1_led");
        step(2);

        set_in(4'b0001, {3'b000, 3'b000, 3'b000, 3'b100}, 4'b0000);
        do_reset();
        for (int k = 1; k <= 12; k++)
            expect_k(k, 4'b0001, 1'b1, pwm_slot(k) ? 3'b100 : 3'b000, "t2_single_pwm");
        step(12);

        set_in(4'b0100, {3'b000, 3'b010, 3'b000, 3'b001}, 4'b0000);
        do_reset();
        for (int k = 1; k <= 13; k++)
            expect_k(k, k <= 8 ? 4'b0100 : 4'b0001, 1'b1,
                     pwm_slot(k) ? (k <= 9 ? 3'b010 : 3'b001) : 3'b000, "t3_priority_lock");
        step(1);
        bus.i_req = 4'b0101;
        step(12);

        set_in(4'b0001, {3'b000, 3'b000, 3'b000, 3'b100}, 4'b0000);
        do_reset();
        for (int k = 1; k <= 12; k++)
            expect_k(k, k <= 8 ? 4'b0001 : 4'b0000, k <= 8,
                     (pwm_slot(k) && k <= 9) ? 3'b100 : 3'b000, "t4_release");
        step(2);
        bus.i_req = 4'b0000;
        step(10);

        set_in(4'b0010, {3'b000, 3'b000, 3'b111, 3'b000}, 4'b0010);
        do_reset();
        for (int k = 1; k <= 24; k++)
            expect_k(k, 4'b0010, 1'b1,
                     (pwm_slot(k) && ((k - 1) / 8) % 2 == 0) ? 3'b111 : 3'b000, "t5_blink");
        step(24);

        set_in(4'b0001, {3'b000, 3'b000, 3'b000, 3'b100}, 4'b0000);
        do_reset();
        expect_k(1, 4'b0001, 1'b1, 3'b000, "t6_grant");
        expect_k(2, 4'b0001, 1'b1, 3'b100, "t6_led_on");
        step(2);
        nrst = 1'b0;
        set_in(4'b1000, {3'b001, 3'b000, 3'b000, 3'b100}, 4'b0000);
        expect_k(3, 4'b0000, 1'b0, 3'b000, "t6_mid_reset");
        step(1);
        nrst = 1'b1;
        expect_k(4, 4'b1000, 1'b1, 3'b000, "t6_regrant");
        expect_k(5, 4'b1000, 1'b1, 3'b001, "t6_led_blue");
        step(2);

        step(3);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries unchecked, expected 0", sb.size());
            compared += sb.size();
            mismatched += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
